// File: rtl/branch_resolve_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve_unit_pkg
// Description : Shared CPU constants for the branch resolve unit. Holds the
//               B-type funct3 encodings, the control-flow op enum and the
//               registered result record.
// Revision    : 1.0 - initial release
// ============================================================================
package branch_resolve_unit_pkg;

  // Widest supported XLEN. The result record is sized for it so that one
  // struct serves both RV32 and RV64 builds.
  localparam int XLEN_MAX = 64;

  // B-type branch conditions (funct3)
  localparam logic [2:0] BEQ  = 3'b000;
  localparam logic [2:0] BNE  = 3'b001;
  localparam logic [2:0] BLT  = 3'b100;
  localparam logic [2:0] BGE  = 3'b101;
  localparam logic [2:0] BLTU = 3'b110;
  localparam logic [2:0] BGEU = 3'b111;

  typedef enum logic [1:0] {
    CF_NONE = 2'd0,
    CF_BR   = 2'd1,
    CF_JAL  = 2'd2,
    CF_JALR = 2'd3
  } cf_op_t;

  typedef struct packed {
    logic                taken;
    logic [XLEN_MAX-1:0] target;
    logic [XLEN_MAX-1:0] link;
    logic                mispredict;
    logic                misalign;
  } br_result_t;

endpackage
`default_nettype wire

// File: rtl/branch_resolve_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve_unit_if
// Description : Request/result handshake bundle of the branch resolve unit.
//               slave = the unit, master = the issue stage / consumer side.
// Revision    : 1.0 - initial release
// ============================================================================
interface branch_resolve_unit_if
  import branch_resolve_unit_pkg::*;
#(
  parameter int XLEN = 64
) ();

  // request side
  logic            in_valid_i;
  logic            in_ready_o;
  logic [XLEN-1:0] pc_i;
  logic [XLEN-1:0] opr_a_i;
  logic [XLEN-1:0] opr_b_i;
  logic [XLEN-1:0] imm_i;
  cf_op_t          op_i;
  logic [2:0]      funct3_i;
  logic            pred_taken_i;
  logic [XLEN-1:0] pred_target_i;

  // result side
  logic            out_valid_o;
  logic            out_ready_i;
  logic            taken_o;
  logic [XLEN-1:0] target_o;
  logic [XLEN-1:0] link_o;
  logic            mispredict_o;
  logic [XLEN-1:0] redirect_pc_o;
  logic            misalign_o;

  modport slave (
    input  in_valid_i, pc_i, opr_a_i, opr_b_i, imm_i, op_i, funct3_i,
           pred_taken_i, pred_target_i, out_ready_i,
    output in_ready_o, out_valid_o, taken_o, target_o, link_o,
           mispredict_o, redirect_pc_o, misalign_o
  );

  modport master (
    output in_valid_i, pc_i, opr_a_i, opr_b_i, imm_i, op_i, funct3_i,
           pred_taken_i, pred_target_i, out_ready_i,
    input  in_ready_o, out_valid_o, taken_o, target_o, link_o,
           mispredict_o, redirect_pc_o, misalign_o
  );

endinterface
`default_nettype wire

// File: rtl/branch_resolve_unit_cond.sv
`default_nettype none
// ============================================================================
// Module      : branch_cond_eval
// Description : Combinational B-type condition evaluator (funct3, a, b ->
//               taken). Reserved encodings 010/011 resolve not-taken.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_cond_eval
  import branch_resolve_unit_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            taken_o
);

  // Select the comparison named by funct3
  always_comb begin
    taken_o = 1'b0;
    case (funct3_i)
      BEQ:     taken_o = (a_i == b_i);
      BNE:     taken_o = (a_i != b_i);
      BLT:     taken_o = ($signed(a_i) <  $signed(b_i));
      BGE:     taken_o = ($signed(a_i) >= $signed(b_i));
      BLTU:    taken_o = (a_i <  b_i);
      BGEU:    taken_o = (a_i >= b_i);
      default: taken_o = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve_unit
// Description : One-stage registered branch/jump resolver. Computes taken,
//               target, link, mispredict and misalign, holds them in an
//               output register under valid/ready, and keeps saturating
//               handoff / mispredict counters.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int HAS_C = 0,
  parameter int CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 flush_i,
  input  logic                 stat_clr_i,
  branch_resolve_unit_if.slave bus,
  output logic [CNT_W-1:0]     br_cnt_o,
  output logic [CNT_W-1:0]     mispred_cnt_o
);

  logic            cond_taken;
  logic [XLEN-1:0] pc_sum;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] target_d;
  logic [XLEN-1:0] link_d;
  logic            taken_d;
  logic            misalign_d;
  logic            mispred_raw;
  logic            accept;
  logic            handoff;
  br_result_t      res_d;
  br_result_t      res_q;
  logic            valid_q;
  logic [CNT_W-1:0] br_cnt_q;
  logic [CNT_W-1:0] mispred_cnt_q;

  branch_cond_eval #(.XLEN(XLEN)) u_cond (
    .funct3_i (bus.funct3_i),
    .a_i      (bus.opr_a_i),
    .b_i      (bus.opr_b_i),
    .taken_o  (cond_taken)
  );

  // All adders wrap modulo 2^XLEN
  assign pc_sum   = bus.pc_i + bus.imm_i;
  assign jalr_sum = bus.opr_a_i + bus.imm_i;
  assign link_d   = bus.pc_i + XLEN'(4);

  // Decode op into taken and target
  always_comb begin
    taken_d  = 1'b0;
    target_d = pc_sum;
    case (bus.op_i)
      CF_BR:   taken_d = cond_taken;
      CF_JAL:  taken_d = 1'b1;
      CF_JALR: begin
        taken_d  = 1'b1;
        target_d = {jalr_sum[XLEN-1:1], 1'b0};
      end
      default: taken_d = 1'b0;
    endcase
  end

  // Without compressed instructions a taken target must be word aligned;
  // with them bit 0 is always clear so nothing can be misaligned.
  generate
    if (HAS_C == 0) begin : g_align4
      assign misalign_d = taken_d & target_d[1];
    end else begin : g_align2
      assign misalign_d = 1'b0;
    end
  endgenerate

  assign mispred_raw = (taken_d != bus.pred_taken_i) |
                       (taken_d & bus.pred_taken_i & (target_d != bus.pred_target_i));

  // A misaligned target traps instead of redirecting, so it is never a mispredict
  assign res_d = '{taken:      taken_d,
                   target:     XLEN_MAX'(target_d),
                   link:       XLEN_MAX'(link_d),
                   mispredict: mispred_raw & ~misalign_d,
                   misalign:   misalign_d};

  assign bus.in_ready_o = ~flush_i & (~valid_q | bus.out_ready_i);
  assign accept         = bus.in_valid_i & bus.in_ready_o;
  assign handoff        = valid_q & bus.out_ready_i;

  // Output pipeline register: load on accept, drain on handoff, drop on flush
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= 1'b0;
      res_q   <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q <= 1'b1;
      res_q   <= res_d;
    end else if (bus.out_ready_i) begin
      valid_q <= 1'b0;
    end
  end

  // Saturating statistics; clear takes priority over a same-cycle handoff
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      br_cnt_q      <= '0;
      mispred_cnt_q <= '0;
    end else if (stat_clr_i) begin
      br_cnt_q      <= '0;
      mispred_cnt_q <= '0;
    end else if (handoff) begin
      if (br_cnt_q != '1)
        br_cnt_q <= br_cnt_q + CNT_W'(1);
      if (res_q.mispredict && (mispred_cnt_q != '1))
        mispred_cnt_q <= mispred_cnt_q + CNT_W'(1);
    end
  end

  assign bus.out_valid_o   = valid_q;
  assign bus.taken_o       = res_q.taken;
  assign bus.target_o      = res_q.target[XLEN-1:0];
  assign bus.link_o        = res_q.link[XLEN-1:0];
  assign bus.mispredict_o  = res_q.mispredict;
  assign bus.misalign_o    = res_q.misalign;
  assign bus.redirect_pc_o = res_q.taken ? res_q.target[XLEN-1:0] : res_q.link[XLEN-1:0];
  assign br_cnt_o          = br_cnt_q;
  assign mispred_cnt_o     = mispred_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_resolve_unit
// Description : Directed self-checking bench for branch_resolve_unit
//               (XLEN=64, HAS_C=0, CNT_W=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_resolve_unit;
  import branch_resolve_unit_pkg::*;

  localparam int XLEN  = 64;
  localparam int CNT_W = 4;
  localparam logic [63:0] M1 = 64'hFFFF_FFFF_FFFF_FFFF;

  logic clk;
  logic resetn;
  logic flush_i;
  logic stat_clr_i;
  logic [CNT_W-1:0] br_cnt_o;
  logic [CNT_W-1:0] mispred_cnt_o;
  int checks;
  int errors;

  branch_resolve_unit_if #(.XLEN(XLEN)) bus ();

  branch_resolve_unit #(.XLEN(XLEN), .HAS_C(0), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .flush_i       (flush_i),
    .stat_clr_i    (stat_clr_i),
    .bus           (bus),
    .br_cnt_o      (br_cnt_o),
    .mispred_cnt_o (mispred_cnt_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input cf_op_t op, input logic [2:0] f3, input logic [63:0] pc,
                         input logic [63:0] a, input logic [63:0] b, input logic [63:0] imm,
                         input logic pt, input logic [63:0] ptgt);
    bus.op_i          = op;
    bus.funct3_i      = f3;
    bus.pc_i          = pc;
    bus.opr_a_i       = a;
    bus.opr_b_i       = b;
    bus.imm_i         = imm;
    bus.pred_taken_i  = pt;
    bus.pred_target_i = ptgt;
    bus.in_valid_i    = 1'b1;
  endtask

  // One request with out_ready_i=1: check the result, then let it drain.
  task automatic run_vec(input string tag, input cf_op_t op, input logic [2:0] f3,
                         input logic [63:0] pc, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] imm, input logic pt, input logic [63:0] ptgt,
                         input logic e_tk, input logic [63:0] e_tgt, input logic e_mp,
                         input logic e_mis, input logic [63:0] e_red);
    set_req(op, f3, pc, a, b, imm, pt, ptgt);
    tick();
    bus.in_valid_i = 1'b0;
    chk({tag, ".valid"},    64'(bus.out_valid_o),  64'd1);
    chk({tag, ".taken"},    64'(bus.taken_o),      64'(e_tk));
    chk({tag, ".target"},   bus.target_o,          e_tgt);
    chk({tag, ".link"},     bus.link_o,            pc + 64'd4);
    chk({tag, ".mispred"},  64'(bus.mispredict_o), 64'(e_mp));
    chk({tag, ".misalign"}, 64'(bus.misalign_o),   64'(e_mis));
    chk({tag, ".redirect"}, bus.redirect_pc_o,     e_red);
    tick();
    chk({tag, ".drained"},  64'(bus.out_valid_o),  64'd0);
  endtask

  task automatic clear_stats();
    stat_clr_i = 1'b1;
    tick();
    stat_clr_i = 1'b0;
    chk("clr.br",      64'(br_cnt_o),      64'd0);
    chk("clr.mispred", 64'(mispred_cnt_o), 64'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    resetn = 1'b0;
    flush_i = 1'b0;
    stat_clr_i = 1'b0;
    bus.in_valid_i = 1'b0;
    bus.out_ready_i = 1'b1;
    set_req(CF_NONE, 3'b000, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0, 64'd0);
    bus.in_valid_i = 1'b0;

    // ---- reset state ----
    repeat (2) @(posedge clk);
    #1;
    chk("rst.valid",   64'(bus.out_valid_o), 64'd0);
    chk("rst.taken",   64'(bus.taken_o),     64'd0);
    chk("rst.target",  bus.target_o,         64'd0);
    chk("rst.link",    bus.link_o,           64'd0);
    chk("rst.br",      64'(br_cnt_o),        64'd0);
    chk("rst.mispred", 64'(mispred_cnt_o),   64'd0);
    resetn = 1'b1;
    #1;
    chk("rst.ready",   64'(bus.in_ready_o),  64'd1);

    // ---- directed resolve vectors ----
    run_vec("blt",   CF_BR,   BLT,    64'h1000, M1, 64'd1, 64'h40, 1'b0, 64'h0,
            1'b1, 64'h1040, 1'b1, 1'b0, 64'h1040);
    chk("blt.br", 64'(br_cnt_o), 64'd1);
    chk("blt.mp", 64'(mispred_cnt_o), 64'd1);
    run_vec("bltu",  CF_BR,   BLTU,   64'h2000, M1, 64'd1, 64'h10, 1'b0, 64'h0,
            1'b0, 64'h2010, 1'b0, 1'b0, 64'h2004);
    run_vec("jalr",  CF_JALR, 3'b000, 64'h3000, 64'h1001, 64'd0, 64'd2, 1'b1, 64'h1002,
            1'b1, 64'h1002, 1'b0, 1'b1, 64'h1002);
    run_vec("beq",   CF_BR,   BEQ,    64'h100, 64'd5, 64'd5, 64'hFFFF_FFFF_FFFF_FFF8, 1'b1, 64'hF8,
            1'b1, 64'hF8, 1'b0, 1'b0, 64'hF8);
    run_vec("bne",   CF_BR,   BNE,    64'h200, 64'd1, 64'd2, 64'h20, 1'b1, 64'h0,
            1'b1, 64'h220, 1'b1, 1'b0, 64'h220);
    run_vec("f3rsv", CF_BR,   3'b010, 64'h300, 64'd0, 64'd0, 64'h20, 1'b0, 64'h0,
            1'b0, 64'h320, 1'b0, 1'b0, 64'h304);
    run_vec("bge",   CF_BR,   BGE,    64'h400, M1, 64'd1, 64'h40, 1'b1, 64'h440,
            1'b0, 64'h440, 1'b1, 1'b0, 64'h404);
    run_vec("bgeu",  CF_BR,   BGEU,   64'h400, M1, 64'd1, 64'h40, 1'b1, 64'h440,
            1'b1, 64'h440, 1'b0, 1'b0, 64'h440);
    run_vec("jalwrap", CF_JAL, 3'b000, 64'hFFFF_FFFF_FFFF_FFF0, 64'd0, 64'd0, 64'h20, 1'b0, 64'h0,
            1'b1, 64'h10, 1'b1, 1'b0, 64'h10);
    run_vec("none",  CF_NONE, 3'b000, 64'h500, 64'd0, 64'd0, 64'h8, 1'b0, 64'h0,
            1'b0, 64'h508, 1'b0, 1'b0, 64'h504);
    chk("vec.br", 64'(br_cnt_o), 64'd10);
    chk("vec.mp", 64'(mispred_cnt_o), 64'd4);
    clear_stats();

    // ---- backpressure: result A held while B waits ----
    bus.out_ready_i = 1'b0;
    set_req(CF_BR, BEQ, 64'h500, 64'd7, 64'd7, 64'h20, 1'b1, 64'h520);
    tick();
    set_req(CF_JAL, 3'b000, 64'h600, 64'd0, 64'd0, 64'h40, 1'b0, 64'h0);
    for (int i = 0; i < 3; i++) begin
      chk("bp.ready",  64'(bus.in_ready_o),  64'd0);
      chk("bp.valid",  64'(bus.out_valid_o), 64'd1);
      chk("bp.target", bus.target_o,         64'h520);
      chk("bp.br",     64'(br_cnt_o),        64'd0);
      tick();
    end
    bus.out_ready_i = 1'b1;
    #1;
    chk("bp.ready_rel", 64'(bus.in_ready_o), 64'd1);
    tick();
    bus.in_valid_i = 1'b0;
    chk("bp.b_valid",  64'(bus.out_valid_o),  64'd1);
    chk("bp.b_target", bus.target_o,          64'h640);
    chk("bp.b_mp",     64'(bus.mispredict_o), 64'd1);
    chk("bp.br1",      64'(br_cnt_o),         64'd1);
    tick();
    chk("bp.br2",      64'(br_cnt_o),         64'd2);
    chk("bp.mp2",      64'(mispred_cnt_o),    64'd1);
    chk("bp.empty",    64'(bus.out_valid_o),  64'd0);

    // ---- flush with a stalled result ----
    bus.out_ready_i = 1'b0;
    set_req(CF_JAL, 3'b000, 64'h700, 64'd0, 64'd0, 64'h10, 1'b0, 64'h0);
    tick();
    chk("fl.valid", 64'(bus.out_valid_o), 64'd1);
    flush_i = 1'b1;
    #1;
    chk("fl.ready", 64'(bus.in_ready_o), 64'd0);
    tick();
    flush_i = 1'b0;
    bus.in_valid_i = 1'b0;
    chk("fl.killed", 64'(bus.out_valid_o), 64'd0);
    chk("fl.br",     64'(br_cnt_o),        64'd2);
    tick();
    chk("fl.noacc",  64'(bus.out_valid_o), 64'd0);

    // ---- asynchronous reset mid-operation ----
    set_req(CF_JAL, 3'b000, 64'h780, 64'd0, 64'd0, 64'h10, 1'b0, 64'h0);
    tick();
    bus.in_valid_i = 1'b0;
    chk("ar.valid_pre", 64'(bus.out_valid_o), 64'd1);
    #2;
    resetn = 1'b0;
    #1;
    chk("ar.valid",   64'(bus.out_valid_o), 64'd0);
    chk("ar.taken",   64'(bus.taken_o),     64'd0);
    chk("ar.br",      64'(br_cnt_o),        64'd0);
    chk("ar.mispred", 64'(mispred_cnt_o),   64'd0);
    tick();
    resetn = 1'b1;
    bus.out_ready_i = 1'b1;
    #1;
    chk("ar.ready", 64'(bus.in_ready_o), 64'd1);

    // ---- saturation: 17 mispredicted handoffs into 4-bit counters ----
    set_req(CF_JAL, 3'b000, 64'h800, 64'd0, 64'd0, 64'h10, 1'b0, 64'h0);
    for (int i = 0; i < 17; i++) tick();
    bus.in_valid_i = 1'b0;
    tick();
    chk("sat.br",      64'(br_cnt_o),      64'hF);
    chk("sat.mispred", 64'(mispred_cnt_o), 64'hF);

    // ---- clear beats a same-cycle handoff ----
    set_req(CF_JAL, 3'b000, 64'h900, 64'd0, 64'd0, 64'h10, 1'b0, 64'h0);
    tick();
    bus.in_valid_i = 1'b0;
    chk("clrhs.valid", 64'(bus.out_valid_o), 64'd1);
    stat_clr_i = 1'b1;
    tick();
    stat_clr_i = 1'b0;
    chk("clrhs.br",      64'(br_cnt_o),      64'd0);
    chk("clrhs.mispred", 64'(mispred_cnt_o), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
